// File: rtl/adsr_pkg.sv
// Shared types and constants for the gated ADSR amplitude envelope.
package adsr_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } adsr_state_t;

    localparam logic [15:0] PCM_MID = 16'h8000;
    localparam logic [15:0] ENV_MAX = 16'hFFFF;

    // 4-bit sustain level replicated across the word so 0xF reaches full scale.
    function automatic logic [15:0] sustain_target(input logic [3:0] s);
        return {s, s, s, s};
    endfunction

endpackage

// File: rtl/adsr_rate_tick.sv
// Free-running envelope prescaler: one-cycle tick each time the counter wraps.
module adsr_rate_tick #(
    parameter int unsigned PRESCALE_BITS = 8
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    generate
        if (PRESCALE_BITS == 0) begin : g_every_cycle
            logic unused_ports;
            assign unused_ports = clk ^ reset;
            assign tick = 1'b1;
        end else begin : g_count
            logic [PRESCALE_BITS-1:0] count;

            always_ff @(posedge clk) begin
                if (reset) begin
                    count <= '0;
                end else begin
                    count <= count + PRESCALE_BITS'(1);
                end
            end

            assign tick = &count;
        end
    endgenerate

endmodule

// File: rtl/adsr_envelope.sv
// Gated ADSR envelope scaling offset-binary PCM around its midpoint.
// Define ADSR_EXP_RELEASE_EN for an exponential release (step = max(1, env >> release_rate)).
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int unsigned PRESCALE_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gate,
    input  logic [3:0]  attack_rate,
    input  logic [3:0]  decay_rate,
    input  logic [3:0]  sustain_level,
    input  logic [3:0]  release_rate,
    input  logic [15:0] pcm_in,
    output logic [15:0] pcm_out,
    output logic [15:0] env_out,
    output logic        busy
);

    adsr_state_t state, state_nxt;
    logic [15:0] env, env_nxt;
    logic        gate_q;
    logic        tick;
    logic        rise, fall;
    logic [15:0] target;
    logic [3:0]  rate_sel;
    logic [15:0] step;
    logic [16:0] env_ext;

    logic signed [16:0] pcm_delta;
    logic signed [16:0] env_signed;
    logic signed [33:0] prod;
    logic        [15:0] pcm_nxt;
    logic               unused_prod;

    adsr_rate_tick #(
        .PRESCALE_BITS(PRESCALE_BITS)
    ) u_rate_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    always_comb begin
        rise    = gate & ~gate_q;
        fall    = ~gate & gate_q;
        target  = sustain_target(sustain_level);
        env_ext = {1'b0, env};

        case (state)
            ATTACK:  rate_sel = attack_rate;
            DECAY:   rate_sel = decay_rate;
            RELEASE: rate_sel = release_rate;
            default: rate_sel = '0;
        endcase

`ifdef ADSR_EXP_RELEASE_EN
        if (state == RELEASE) begin
            step = env >> release_rate;
            if (step == '0) begin
                step = 16'd1;
            end
        end else begin
            step = 16'd1 << rate_sel;
        end
`else
        step = 16'd1 << rate_sel;
`endif
    end

    // Edges pre-empt the tick: an edge cycle never also applies a step.
    always_comb begin
        state_nxt = state;
        env_nxt   = env;
        if (rise) begin
            state_nxt = ATTACK;
        end else if (fall && state != IDLE) begin
            state_nxt = RELEASE;
        end else begin
            case (state)
                IDLE: begin
                    env_nxt = '0;
                end
                ATTACK: begin
                    if (tick) begin
                        if (env_ext + {1'b0, step} >= {1'b0, ENV_MAX}) begin
                            env_nxt   = ENV_MAX;
                            state_nxt = DECAY;
                        end else begin
                            env_nxt = env + step;
                        end
                    end
                end
                DECAY: begin
                    if (tick) begin
                        if (env_ext <= {1'b0, target} + {1'b0, step}) begin
                            env_nxt   = target;
                            state_nxt = SUSTAIN;
                        end else begin
                            env_nxt = env - step;
                        end
                    end
                end
                SUSTAIN: begin
                    env_nxt = target;
                end
                RELEASE: begin
                    if (tick) begin
                        if (env <= step) begin
                            env_nxt   = '0;
                            state_nxt = IDLE;
                        end else begin
                            env_nxt = env - step;
                        end
                    end
                end
                default: begin
                    env_nxt   = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Signed 17x17 product; >>> 16 is taken as bits [31:16], which floors toward -inf.
    always_comb begin
        pcm_delta  = {1'b0, pcm_in} - {1'b0, PCM_MID};
        env_signed = {1'b0, env};
        prod       = pcm_delta * env_signed;
        pcm_nxt    = PCM_MID + prod[31:16];
    end

    assign unused_prod = ^{prod[33:32], prod[15:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            env     <= '0;
            gate_q  <= 1'b0;
            pcm_out <= PCM_MID;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            env     <= env_nxt;
            gate_q  <= gate;
            pcm_out <= pcm_nxt;
            busy    <= (state_nxt != IDLE);
        end
    end

    assign env_out = env;

endmodule

// File: tb/tb_adsr_envelope.sv
// Scoreboard bench for adsr_envelope: stimulus queues expectations, a negedge monitor checks them.
module tb_adsr_envelope;

    localparam int K_ENV  = 0;
    localparam int K_PCM  = 1;
    localparam int K_ENV4 = 2;

`ifdef ADSR_EXP_RELEASE_EN
    localparam logic [3:0] REL_T4 = 4'd1;
    localparam logic [3:0] REL_T6 = 4'd2;
`else
    localparam logic [3:0] REL_T4 = 4'd15;
    localparam logic [3:0] REL_T6 = 4'd12;
`endif

    typedef struct {
        int unsigned at_cyc;
        int          kind;
        string       name;
        logic [15:0] val;
        logic        busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        gate;
    logic [3:0]  attack_rate, decay_rate, sustain_level, release_rate;
    logic [15:0] pcm_in;
    logic [15:0] pcm_out, env_out;
    logic        busy;
    logic [15:0] pcm_out4, env_out4;
    logic        busy4;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    exp_t        cur;
    logic [15:0] em, st;

    adsr_envelope #(.PRESCALE_BITS(0)) u_dut (
        .clk(clk), .reset(reset), .gate(gate),
        .attack_rate(attack_rate), .decay_rate(decay_rate),
        .sustain_level(sustain_level), .release_rate(release_rate),
        .pcm_in(pcm_in), .pcm_out(pcm_out), .env_out(env_out), .busy(busy)
    );

    adsr_envelope #(.PRESCALE_BITS(4)) u_dut4 (
        .clk(clk), .reset(reset), .gate(gate),
        .attack_rate(attack_rate), .decay_rate(decay_rate),
        .sustain_level(sustain_level), .release_rate(release_rate),
        .pcm_in(pcm_in), .pcm_out(pcm_out4), .env_out(env_out4), .busy(busy4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(int kind, string nm, logic [15:0] v, logic b);
        exp_t e;
        e.at_cyc = cyc;
        e.kind   = kind;
        e.name   = nm;
        e.val    = v;
        e.busy   = b;
        sb.push_back(e);
    endtask

    task automatic chk(string nm, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, req);
        end
    endtask

    // Monitor: pops every expectation due for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at_cyc <= cyc) begin
            cur = sb.pop_front();
            if (cur.at_cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: stale expectation for cyc %0d at cyc %0d", cur.name, cur.at_cyc, cyc);
            end else begin
                case (cur.kind)
                    K_ENV: begin
                        chk({cur.name, ".env"}, env_out, cur.val);
                        chk({cur.name, ".busy"}, {15'd0, busy}, {15'd0, cur.busy});
                    end
                    K_PCM: chk({cur.name, ".pcm"}, pcm_out, cur.val);
                    default: begin
                        chk({cur.name, ".env4"}, env_out4, cur.val);
                        chk({cur.name, ".busy4"}, {15'd0, busy4}, {15'd0, cur.busy});
                    end
                endcase
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; gate = 1'b1;
        attack_rate = 4'd12; decay_rate = 4'd12; sustain_level = 4'h8;
        release_rate = REL_T4; pcm_in = 16'h1234;

        // Reset held with gate high, then rise detected on the first free edge.
        for (int i = 0; i < 3; i++) begin
            step();
            push(K_ENV, "reset", 16'h0000, 1'b0);
            push(K_PCM, "reset", 16'h8000, 1'b0);
        end
        reset = 1'b0;
        pcm_in = 16'h8000;
        step(); push(K_ENV, "rise_edge", 16'h0000, 1'b1);
        for (int k = 1; k <= 15; k++) begin
            step(); push(K_ENV, "attack", 16'(k * 'h1000), 1'b1);
        end
        step(); push(K_ENV, "attack_sat", 16'hFFFF, 1'b1);

        for (int k = 1; k <= 7; k++) begin
            step(); push(K_ENV, "decay", 16'hFFFF - 16'(k * 'h1000), 1'b1);
        end
        step(); push(K_ENV, "decay_to_sustain", 16'h8888, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(); push(K_ENV, "sustain_hold", 16'h8888, 1'b1);
        end
        sustain_level = 4'h4;
        step(); push(K_ENV, "sustain_live", 16'h4444, 1'b1);
        sustain_level = 4'h8;
        step(); push(K_ENV, "sustain_back", 16'h8888, 1'b1);

        gate = 1'b0;
        step(); push(K_ENV, "fall_edge", 16'h8888, 1'b1);
`ifdef ADSR_EXP_RELEASE_EN
        em = 16'h8888;
        while (em != 16'h0000) begin
            st = em >> 1;
            if (st == 16'h0000) st = 16'h0001;
            em = (em <= st) ? 16'h0000 : em - st;
            step(); push(K_ENV, "exp_release", em, em != 16'h0000);
        end
`else
        step(); push(K_ENV, "lin_release1", 16'h0888, 1'b1);
        step(); push(K_ENV, "lin_release2", 16'h0000, 1'b0);
`endif
        step(); push(K_ENV, "idle_after_release", 16'h0000, 1'b0);

        // Scaling: env 0 -> 0x8000 -> 0xFFFF with pcm_in at full scale.
        pcm_in = 16'hFFFF; attack_rate = 4'd15; sustain_level = 4'hF; gate = 1'b1;
        step(); push(K_ENV, "scl_rise", 16'h0000, 1'b1); push(K_PCM, "scl_env0", 16'h8000, 1'b0);
        step(); push(K_ENV, "scl_half", 16'h8000, 1'b1); push(K_PCM, "scl_latency", 16'h8000, 1'b0);
        step(); push(K_ENV, "scl_full", 16'hFFFF, 1'b1); push(K_PCM, "scl_ffff_x_8000", 16'hBFFF, 1'b0);
        step(); push(K_ENV, "scl_sustain", 16'hFFFF, 1'b1); push(K_PCM, "scl_ffff_x_ffff", 16'hFFFE, 1'b0);
        step(); push(K_PCM, "scl_hold", 16'hFFFE, 1'b0);
        pcm_in = 16'h0000;
        step(); push(K_PCM, "scl_0000_x_ffff", 16'h0000, 1'b0);
        pcm_in = 16'h8000;
        step(); push(K_PCM, "scl_mid", 16'h8000, 1'b0);
        pcm_in = 16'h4000;
        step(); push(K_PCM, "scl_4000_x_ffff", 16'h4000, 1'b0);

        // Reset mid-operation aborts to IDLE on that edge.
        reset = 1'b1;
        step(); push(K_ENV, "mid_reset", 16'h0000, 1'b0); push(K_PCM, "mid_reset", 16'h8000, 1'b0);
        reset = 1'b0; gate = 1'b0;
        step(); push(K_ENV, "post_reset_idle", 16'h0000, 1'b0);

        // Retrigger mid-release keeps the envelope; rise cycle applies no step.
        pcm_in = 16'h0000; attack_rate = 4'd12; release_rate = REL_T6; sustain_level = 4'h8;
        gate = 1'b1;
        step(); push(K_ENV, "b_rise", 16'h0000, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step(); push(K_ENV, "b_attack", 16'(k * 'h1000), 1'b1);
        end
        gate = 1'b0;
        step(); push(K_ENV, "b_fall", 16'h4000, 1'b1);
        step(); push(K_ENV, "b_release", 16'h3000, 1'b1);
        gate = 1'b1;
        step(); push(K_ENV, "b_retrigger", 16'h3000, 1'b1);
        for (int k = 4; k <= 8; k++) begin
            step(); push(K_ENV, "b_resume", 16'(k * 'h1000), 1'b1);
        end
        step(); push(K_ENV, "b_resume", 16'h9000, 1'b1); push(K_PCM, "scl_0000_x_8000", 16'h4000, 1'b0);

        // Prescaled instance: ticks on every 16th edge after reset, independent of gate.
        reset = 1'b1; gate = 1'b0; attack_rate = 4'd4;
        step(); push(K_ENV4, "p4_reset", 16'h0000, 1'b0);
        reset = 1'b0; gate = 1'b1;
        step(); push(K_ENV4, "p4_rise", 16'h0000, 1'b1);
        for (int i = 2; i <= 15; i++) begin
            step(); push(K_ENV4, "p4_wait", 16'h0000, 1'b1);
        end
        step(); push(K_ENV4, "p4_tick1", 16'h0010, 1'b1);
        for (int i = 17; i <= 31; i++) begin
            step(); push(K_ENV4, "p4_hold", 16'h0010, 1'b1);
        end
        step(); push(K_ENV4, "p4_tick2", 16'h0020, 1'b1);

        step();
        step();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
